// File: rtl/rot_input_conditioner.sv
// Synchronises and debounces the two rotary encoder pins, flags accepted edges, counts bounces.
// Latency: a held pin level reaches rota/rotb SYNC_STAGES + DEBOUNCE_CYCLES edges after first sample.
// Backpressure: none; free-running stage that samples on every clk edge.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   rota_raw/rotb_raw  raw encoder pins, asynchronous to clk
//   rota/rotb          debounced channel levels for the quadrature decoder
//   rota_chg/rotb_chg  one-cycle pulse in the cycle the clean level changes
//   glitch_cnt         saturating count of rejected bounces, both channels combined
module rot_input_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rota_raw,
   input  logic       rotb_raw,
   output logic       rota,
   output logic       rotb,
   output logic       rota_chg,
   output logic       rotb_chg,
   output logic [7:0] glitch_cnt
);

   typedef enum logic {STABLE, PENDING} state_t;

   localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0] raw_w;
   logic [1:0] clean_w;
   logic [1:0] chg_w;
   logic [1:0] glitch_w;

   assign raw_w = {rotb_raw, rota_raw};

   for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q;
      state_t                 state_q;
      logic [CNT_W-1:0]       cnt_q;
      logic                   clean_q;
      logic                   chg_q;
      logic                   s_w;

      // Plain shift chain: flops reset high because the encoder idles pulled up.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_q <= '1;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_w[ch]};
         end
      end

      assign s_w = sync_q[SYNC_STAGES-1];

      // A pending transition that sees the old level again is a bounce.
      assign glitch_w[ch] = (state_q == PENDING) && (s_w == clean_q);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            clean_q <= 1'b1;
            chg_q   <= 1'b0;
         end else begin
            chg_q <= 1'b0;
            case (state_q)
               STABLE: begin
                  cnt_q <= '0;
                  if (s_w != clean_q) begin
                     if (DEB_LIM == CNT_ONE) begin
                        clean_q <= s_w;
                        chg_q   <= 1'b1;
                     end else begin
                        state_q <= PENDING;
                        cnt_q   <= CNT_ONE;
                     end
                  end
               end
               PENDING: begin
                  if (s_w == clean_q) begin
                     state_q <= STABLE;
                     cnt_q   <= '0;
                  end else if (cnt_q + CNT_ONE == DEB_LIM) begin
                     // This edge is the DEBOUNCE_CYCLES-th consecutive differing sample.
                     clean_q <= s_w;
                     chg_q   <= 1'b1;
                     state_q <= STABLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  state_q <= STABLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end

      assign clean_w[ch] = clean_q;
      assign chg_w[ch]   = chg_q;
   end

   // Glitch counter: both channels may bounce on the same edge, so add up to 2 and clamp.
   logic [7:0] glitch_q;
   logic [7:0] glitch_d;
   logic [8:0] glitch_sum_w;

   always_comb begin
      glitch_sum_w = {1'b0, glitch_q} + 9'(glitch_w[0]) + 9'(glitch_w[1]);
      glitch_d     = glitch_q;
      if (glitch_sum_w > 9'd255) begin
         glitch_d = 8'hFF;
      end else begin
         glitch_d = glitch_sum_w[7:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         glitch_q <= '0;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign rota       = clean_w[0];
   assign rotb       = clean_w[1];
   assign rota_chg   = chg_w[0];
   assign rotb_chg   = chg_w[1];
   assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_rot_input_conditioner.sv
// Scoreboard bench for rot_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Latency: every held pin change is expected on the clean output 6 edges after it is driven.
// Backpressure: none; the monitor checks each chg pulse against the head of the expected queue.
module tb_rot_input_conditioner;

   localparam int LAT = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       rota_raw;
   logic       rotb_raw;
   logic       rota;
   logic       rotb;
   logic       rota_chg;
   logic       rotb_chg;
   logic [7:0] glitch_cnt;

   typedef struct {
      int   ch;
      logic lvl;
      int   cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc       = 0;
   int   n_checks  = 0;
   int   n_pass    = 0;
   int   n_pulses  = 0;

   rot_input_conditioner #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rota_raw  (rota_raw),
      .rotb_raw  (rotb_raw),
      .rota      (rota),
      .rotb      (rotb),
      .rota_chg  (rota_chg),
      .rotb_chg  (rotb_chg),
      .glitch_cnt(glitch_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act == expv) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: every chg pulse must match the oldest outstanding expectation.
   task automatic handle(input int ch, input logic lvl);
      exp_t e;
      n_pulses++;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_chg: ch=%0d level=%0d at cycle %0d, none expected", ch, lvl, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.ch == ch && e.lvl == lvl && e.cyc == cyc) begin
            n_pass++;
         end else begin
            $display("FAIL chg_event: got ch=%0d level=%0d cycle=%0d, expected ch=%0d level=%0d cycle=%0d",
                     ch, lvl, cyc, e.ch, e.lvl, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rota_chg) handle(0, rota);
      if (rotb_chg) handle(1, rotb);
   end

   // All stimulus is applied 1 time unit after a rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_chg(input int ch, input logic lvl, input int delay);
      exp_t e;
      e.ch  = ch;
      e.lvl = lvl;
      e.cyc = cyc + delay;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 40) begin
         step(1);
         k++;
      end
      chk(name, exp_q.size(), 0);
      step(2);
   endtask

   task automatic bounce(input bit a, input bit b);
      if (a) rota_raw = 1'b0;
      if (b) rotb_raw = 1'b0;
      step(3);
      rota_raw = 1'b1;
      rotb_raw = 1'b1;
      step(8);
   endtask

   initial begin
      int p0;
      rst      = 1'b1;
      rota_raw = 1'b0;
      rotb_raw = 1'b0;
      step(3);

      // 1. reset state, then release with pins held low
      chk("rst_rota", rota, 1);
      chk("rst_rotb", rotb, 1);
      chk("rst_rota_chg", rota_chg, 0);
      chk("rst_rotb_chg", rotb_chg, 0);
      chk("rst_glitch", glitch_cnt, 0);
      rst = 1'b0;
      expect_chg(0, 1'b0, LAT);
      expect_chg(1, 1'b0, LAT);
      drain("release_fall");
      chk("release_rota_low", rota, 0);
      chk("release_rotb_low", rotb, 0);

      // back to idle high
      rota_raw = 1'b1;
      rotb_raw = 1'b1;
      expect_chg(0, 1'b1, LAT);
      expect_chg(1, 1'b1, LAT);
      drain("idle_rise");

      // 2. clean step on channel A only
      rota_raw = 1'b0;
      expect_chg(0, 1'b0, LAT);
      drain("step_a");
      chk("step_rota", rota, 0);
      chk("step_rotb_held", rotb, 1);
      rota_raw = 1'b1;
      expect_chg(0, 1'b1, LAT);
      drain("step_a_restore");
      chk("step_glitch_zero", glitch_cnt, 0);

      // 3. three-cycle bounce on A
      bounce(1'b1, 1'b0);
      chk("bounce_rota", rota, 1);
      chk("bounce_glitch1", glitch_cnt, 1);

      // 4. saturation: single bounce to 2, doubles to 254, then 255 and hold
      bounce(1'b1, 1'b0);
      chk("glitch2", glitch_cnt, 2);
      bounce(1'b1, 1'b1);
      chk("glitch4_double", glitch_cnt, 4);
      repeat (125) bounce(1'b1, 1'b1);
      chk("glitch254", glitch_cnt, 254);
      bounce(1'b1, 1'b1);
      chk("glitch_sat_255", glitch_cnt, 255);
      bounce(1'b1, 1'b1);
      chk("glitch_hold_255", glitch_cnt, 255);
      bounce(1'b0, 1'b1);
      chk("glitch_hold_255_b", glitch_cnt, 255);

      // 5. reset in the middle of a pending transition
      rota_raw = 1'b0;
      step(3);
      rst = 1'b1;
      #1;
      chk("midrst_rota", rota, 1);
      chk("midrst_chg", rota_chg, 0);
      chk("midrst_glitch", glitch_cnt, 0);
      step(2);
      rst = 1'b0;
      expect_chg(0, 1'b0, LAT);
      drain("midrst_relatch");
      chk("midrst_rota_low", rota, 0);
      rota_raw = 1'b1;
      expect_chg(0, 1'b1, LAT);
      drain("midrst_restore");

      // 6. clockwise quadrature sequence, 10 cycles between pin edges
      p0 = n_pulses;
      rota_raw = 1'b0;
      expect_chg(0, 1'b0, LAT);
      step(10);
      rotb_raw = 1'b0;
      expect_chg(1, 1'b0, LAT);
      step(10);
      rota_raw = 1'b1;
      expect_chg(0, 1'b1, LAT);
      step(10);
      rotb_raw = 1'b1;
      expect_chg(1, 1'b1, LAT);
      drain("quad_drain");
      chk("quad_pulses", n_pulses - p0, 4);
      chk("quad_glitch", glitch_cnt, 0);
      chk("quad_rota_end", rota, 1);
      chk("quad_rotb_end", rotb, 1);

      step(5);
      chk("queue_empty_end", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rot_input_conditioner.md
Name: rot_input_conditioner

Overview:
Front-end conditioning stage for the rotary shaft encoder. It synchronises the raw asynchronous rota/rotb pins into the clk domain and debounces each channel independently. The clean, glitch-free rota/rotb it produces drive the quadrature decode stage directly. It also flags each accepted transition and counts rejected bounces for board bring-up diagnostics.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each channel's synchroniser chain (legal 2..4)
DEBOUNCE_CYCLES, 1000, consecutive synchronised samples at the new level needed to accept a transition (legal 1..2^CNT_W-1)
CNT_W, 16, width of each channel's debounce counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rota_raw  input  1  encoder channel A pin, asynchronous
rotb_raw  input  1  encoder channel B pin, asynchronous
rota  output  1  debounced channel A, feeds decode stage
rotb  output  1  debounced channel B, feeds decode stage
rota_chg  output  1  one-cycle pulse, rota changed this cycle
rotb_chg  output  1  one-cycle pulse, rotb changed this cycle
glitch_cnt  output  8  saturating count of rejected bounces, both channels combined

Behaviour:
- Reset (async assert, sync release): all synchroniser flops = 1 (encoder idles high, pulled up); rota = rotb = 1; rota_chg = rotb_chg = 0; glitch_cnt = 0; both channel FSMs in STABLE; counters = 0.
- Synchroniser: SYNC_STAGES-flop chain per channel. The final flop output is the synchronised sample s. No logic between flops.
- Per-channel FSM, two states, all updates on clk rising edge:
  - STABLE: if s == clean, stay and hold counter at 0. If s != clean, go to PENDING with counter = 1. If DEBOUNCE_CYCLES == 1, accept immediately: toggle clean, pulse chg, stay STABLE.
  - PENDING, s != clean: counter += 1. When this is the DEBOUNCE_CYCLES-th consecutive differing edge, toggle clean, assert chg for that one cycle, return to STABLE, counter = 0.
  - PENDING, s == clean (bounced back): return to STABLE, counter = 0, clean unchanged, no chg, and register one glitch.
- Latency: a raw level change held steady is reflected on clean exactly SYNC_STAGES + DEBOUNCE_CYCLES edges after the first edge that samples it. Both channels have identical latency, so quadrature ordering is preserved.
- chg pulses are registered, high in the same cycle clean takes its new value, and never wider than 1 cycle.
- glitch_cnt: +1 per channel glitch per edge. Simultaneous glitches on both channels give +2. Saturates at 255 and never wraps (254 + 2 -> 255).
- Channels are fully independent: a transition on one channel never resets the other channel's counter.
- Reset mid-PENDING aborts the pending transition: no chg pulse, clean returns to 1. After release the full latency applies again.
- Counter never exceeds DEBOUNCE_CYCLES, so no overflow is possible within the legal range.

Test Plan:
(Defaults SYNC_STAGES=2; DEBOUNCE_CYCLES=4 for all scenarios.)
1. Reset: raw=0 during rst -> rota=rotb=1, chg=0, glitch_cnt=0. After release with raw held 0 -> rota and rotb fall on the 6th edge after release; rota_chg and rotb_chg high exactly that one cycle.
2. Clean step: rota_raw 1->0, held, with the first sampling edge as edge 1 -> rota=0 after edge 6, rota_chg=1 only in the cycle after edge 6. rotb unchanged, rotb_chg=0 throughout.
3. Bounce: rota_raw low for 3 cycles then high -> rota stays 1, rota_chg never asserts, glitch_cnt 0->1.
4. Simultaneous bounce on both channels, glitch_cnt preset to 254 by prior bounces -> glitch_cnt = 255. A further double bounce -> stays 255.
5. Reset mid-operation: rota_raw low, rst asserted after 3 edges -> rota=1 immediately, no chg pulse. Release with raw still low -> rota falls after 6 further edges.
6. Quadrature CW sequence (a falls, b falls 10 cycles later, a rises 10 later, b rises 10 later) -> rota/rotb reproduce the same order and 10-cycle spacing, each delayed 6 edges; 4 chg pulses total; glitch_cnt 0.
